pm_step_counter: RTL and testbench

PM_STEP_COUNTER -- requirements
Module: pm_step_counter

---
 rtl/pm_step_counter.sv | 231 +++++++++++++++++++++++
 tb/tb_pm_step_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pm_step_counter.sv
// ---------------------------------------------------------------------------
// pm_step_counter
//
// Bounded up/down step counter for user-facing settings (clock minutes,
// volume, etc.). Each rising edge of up/down moves the value one step, either
// wrapping or saturating at the [min_val, max_val] bounds. Load has priority
// over stepping and clamps into the bounds.
//
// Optional build macro: PM_STEP_AUTOREPEAT_EN
//   Defined   -> a held up/down key auto-repeats: after REPEAT_DELAY cycles
//                held it steps once, then once every REPEAT_PERIOD cycles.
//   Undefined -> only edge-triggered steps (no repeat FSM, no counters).
//
// Parameters
//   WIDTH          counter / bound width (2..16)
//   REPEAT_DELAY   cycles held before the first auto-repeat step
//   REPEAT_PERIOD  cycles between auto-repeat steps
//
// Ports
//   clk         in   clock, all state on rising edge
//   rst         in   synchronous active-low reset
//   en          in   step enable (does not gate load)
//   up / down   in   step requests, level; step on 0->1
//   load        in   load load_value (clamped) every cycle high
//   load_value  in   value to load
//   init_value  in   value taken during reset (not clamped)
//   min_val     in   inclusive lower bound
//   max_val     in   inclusive upper bound
//   wrap_mode   in   1 = wrap at bounds, 0 = saturate
//   value       out  registered counter value
//   carry       out  one-cycle pulse on an up-wrap
//   borrow      out  one-cycle pulse on a down-wrap
//   at_min      out  value == min_val (combinational)
//   at_max      out  value == max_val (combinational)
// ---------------------------------------------------------------------------
module pm_step_counter #(
    parameter int WIDTH         = 7,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] init_value,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             wrap_mode,
    output logic [WIDTH-1:0] value,
    output logic             carry,
    output logic             borrow,
    output logic             at_min,
    output logic             at_max
);

    // Elaboration-time parameter sanity
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("pm_step_counter: WIDTH must be 2..16");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("pm_step_counter: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             up_prev_q, down_prev_q;

    logic step_up, step_down;
    logic rep_up, rep_dn;
    logic bounds_ok, out_rng;
    logic do_up, do_dn;

    assign step_up   = up & ~up_prev_q;
    assign step_down = down & ~down_prev_q;

`ifdef PM_STEP_AUTOREPEAT_EN
    // -----------------------------------------------------------------------
    // Auto-repeat FSM. One FSM shared by both directions; dir_up_q remembers
    // which key started the sequence.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {RS_IDLE, RS_DELAY, RS_REPEAT} rep_state_e;

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_e       rs_q, rs_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held, start;

    // Key still held in the active direction with nothing that cancels repeat
    assign held  = (dir_up_q ? up : down) & ~(up & down) & en & ~load;
    // A fresh edge step that is allowed to arm the repeat
    assign start = (step_up | step_down) & ~(up & down) & en & ~load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rs_q     <= RS_IDLE;
            dir_up_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rs_q     <= rs_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rs_d     = rs_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        case (rs_q)
            RS_DELAY, RS_REPEAT: begin
                if (held) begin
                    if (cnt_q == ((rs_q == RS_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        rs_d  = RS_REPEAT;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (start) begin
                    // Key released and the other key pressed on the same edge
                    rs_d     = RS_DELAY;
                    dir_up_d = step_up;
                    cnt_d    = '0;
                end else begin
                    rs_d  = RS_IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                if (start) begin
                    rs_d     = RS_DELAY;
                    dir_up_d = step_up;
                    cnt_d    = '0;
                end
            end
        endcase
    end

    logic rep_fire;
    always_comb begin
        rep_fire = 1'b0;
        case (rs_q)
            RS_DELAY:  rep_fire = held & (cnt_q == DELAY_LAST);
            RS_REPEAT: rep_fire = held & (cnt_q == PERIOD_LAST);
            default:   rep_fire = 1'b0;
        endcase
        rep_up = rep_fire & dir_up_q;
        rep_dn = rep_fire & ~dir_up_q;
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Value next-state
    // -----------------------------------------------------------------------
    assign bounds_ok = (min_val <= max_val);
    assign out_rng   = (value_q > max_val) || (value_q < min_val);
    // Simultaneous up and down edges cancel each other
    assign do_up     = (step_up & ~step_down) | rep_up;
    assign do_dn     = (step_down & ~step_up) | rep_dn;

    always_comb begin
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            if (!bounds_ok)
                value_d = load_value;
            else if (load_value < min_val)
                value_d = min_val;
            else if (load_value > max_val)
                value_d = max_val;
            else
                value_d = load_value;
        end else if (en && bounds_ok) begin
            if (do_up) begin
                if (out_rng) begin
                    value_d = min_val;
                end else if (value_q < max_val) begin
                    value_d = value_q + WIDTH'(1);
                end else if (wrap_mode) begin
                    value_d = min_val;
                    carry_d = 1'b1;
                end
            end else if (do_dn) begin
                if (out_rng) begin
                    value_d = max_val;
                end else if (value_q > min_val) begin
                    value_d = value_q - WIDTH'(1);
                end else if (wrap_mode) begin
                    value_d  = max_val;
                    borrow_d = 1'b1;
                end
            end
        end
    end

    // prev levels reset to 1 so a key held through reset release is ignored
    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q     <= init_value;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
        end else begin
            value_q     <= value_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            up_prev_q   <= up;
            down_prev_q <= down;
        end
    end

    assign value  = value_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign at_min = (value_q == min_val);
    assign at_max = (value_q == max_val);

endmodule

// File: tb/tb_pm_step_counter.sv
// Bench for pm_step_counter: reference model updated on each rising edge,
// per-cycle comparison on the falling edge, plus literal spot checks.
module tb_pm_step_counter;
    localparam int W  = 7;
    localparam int RD = 50;
    localparam int RP = 10;

    logic         clk = 1'b0;
    logic         rst, en, up, down, load, wrap_mode;
    logic [W-1:0] load_value, init_value, min_val, max_val;
    logic [W-1:0] value;
    logic         carry, borrow, at_min, at_max;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pm_step_counter #(.WIDTH(W), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
        .load_value(load_value), .init_value(init_value),
        .min_val(min_val), .max_val(max_val), .wrap_mode(wrap_mode),
        .value(value), .carry(carry), .borrow(borrow),
        .at_min(at_min), .at_max(at_max)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mval;
    bit mcarry, mborrow, mupp, mdnp, mvalid = 1'b0;
    bit ract, rdir;   // repeat sequence active, direction (1 = up)
    int rage;         // edges elapsed since the edge that started the sequence

    always @(posedge clk) begin
        int mn, mx, lv;
        bit su, sd, du, dd, rep, edge_up, edge_dn;
        mn = int'(min_val);
        mx = int'(max_val);
        lv = int'(load_value);
        if (!rst) begin
            mval = int'(init_value);
            mcarry = 0; mborrow = 0; mupp = 1; mdnp = 1;
            ract = 0; rage = 0;
            mvalid = 1;
        end else begin
            su = up && !mupp;
            sd = down && !mdnp;
            mupp = up; mdnp = down;
            mcarry = 0; mborrow = 0;
            edge_up = su && !sd;
            edge_dn = sd && !su;
            du = edge_up; dd = edge_dn;
            rep = 0;
            if (ract) begin
                if (!(rdir ? up : down) || (up && down) || !en || load) ract = 0;
                else begin
                    rage++;
                    if (rage == RD || (rage > RD && (rage - RD) % RP == 0)) rep = 1;
                end
            end
`ifdef PM_STEP_AUTOREPEAT_EN
            if (!ract && (su || sd) && !(up && down) && en && !load) begin
                ract = 1; rdir = su; rage = 0;
            end
`endif
            if (rep) begin
                if (rdir) du = 1; else dd = 1;
            end
            if (load) begin
                if (mn > mx) mval = lv;
                else if (lv < mn) mval = mn;
                else if (lv > mx) mval = mx;
                else mval = lv;
            end else if (en && mn <= mx) begin
                if (du) begin
                    if (mval > mx || mval < mn) mval = mn;
                    else if (mval < mx) mval = mval + 1;
                    else if (wrap_mode) begin mval = mn; mcarry = 1; end
                end else if (dd) begin
                    if (mval > mx || mval < mn) mval = mx;
                    else if (mval > mn) mval = mval - 1;
                    else if (wrap_mode) begin mval = mx; mborrow = 1; end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mvalid) begin
            chk("value",  int'(value),  mval);
            chk("carry",  int'(carry),  int'(mcarry));
            chk("borrow", int'(borrow), int'(mborrow));
            chk("at_min", int'(at_min), int'(mval == int'(min_val)));
            chk("at_max", int'(at_max), int'(mval == int'(max_val)));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 0; en = 1; up = 0; down = 0; load = 0; wrap_mode = 1;
        load_value = 0; init_value = 30; min_val = 0; max_val = 59;
        cyc(2);
        chk("rst_value", int'(value), 30);
        chk("rst_carry", int'(carry), 0);
        chk("rst_borrow", int'(borrow), 0);
        rst = 1; cyc();
        chk("post_rst_hold", int'(value), 30);

        // wrap from max on up
        load = 1; load_value = 59; cyc(); load = 0;
        chk("load59", int'(value), 59);
        chk("load59_at_max", int'(at_max), 1);
        up = 1; cyc();
        chk("wrap_up_value", int'(value), 0);
        chk("wrap_up_carry", int'(carry), 1);
        up = 0; cyc();
        chk("carry_one_cycle", int'(carry), 0);

        // saturate at min on down
        wrap_mode = 0;
        down = 1; cyc();
        chk("sat_down_value", int'(value), 0);
        chk("sat_down_borrow", int'(borrow), 0);
        chk("sat_down_at_min", int'(at_min), 1);
        down = 0; cyc();

        // held level gives a single step; simultaneous edges cancel
        up = 1; cyc(20);
        chk("held_one_step", int'(value), 1);
        up = 0; cyc();
        up = 1; down = 1; cyc();
        chk("both_edges_no_step", int'(value), 1);
        up = 0; down = 0; cyc();

        // load clamps and beats a step
        min_val = 10;
        load = 1; load_value = 99; up = 1; cyc();
        chk("load_clamp_max", int'(value), 59);
        load = 0; up = 0; cyc();
        chk("load_clamp_hold", int'(value), 59);

        // out of range after a bound change
        min_val = 0; max_val = 40;
        up = 1; cyc();
        chk("oor_up_to_min", int'(value), 0);
        chk("oor_up_no_carry", int'(carry), 0);
        up = 0; wrap_mode = 1; cyc();
        down = 1; cyc();
        chk("wrap_down_value", int'(value), 40);
        chk("wrap_down_borrow", int'(borrow), 1);
        down = 0; max_val = 30; cyc();
        down = 1; cyc();
        chk("oor_down_to_max", int'(value), 30);
        chk("oor_down_no_borrow", int'(borrow), 0);
        down = 0; cyc();

        // en low blocks steps; inverted bounds block steps, load unclamped
        en = 0; up = 1; cyc();
        chk("en_low_hold", int'(value), 30);
        up = 0; en = 1; cyc();
        min_val = 50; max_val = 20;
        up = 1; cyc();
        chk("inv_bounds_hold", int'(value), 30);
        up = 0; load = 1; load_value = 5; cyc();
        chk("inv_bounds_load_raw", int'(value), 5);
        load = 0; min_val = 0; max_val = 59; cyc();

        // key held through reset release
        rst = 0; init_value = 30; up = 1; cyc(2);
        chk("rst_held_value", int'(value), 30);
        rst = 1; cyc(3);
        chk("held_through_rst", int'(value), 30);
        up = 0; cyc();
        chk("released_no_step", int'(value), 30);
        up = 1; cyc();
        chk("repress_step", int'(value), 31);
        up = 0; cyc();

`ifdef PM_STEP_AUTOREPEAT_EN
        load = 1; load_value = 0; cyc(); load = 0;
        up = 1;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (k == 1)  chk("rep_k1",  int'(value), 1);
            if (k == 50) chk("rep_k50", int'(value), 1);
            if (k == 51) chk("rep_k51", int'(value), 2);
            if (k == 61) chk("rep_k61", int'(value), 3);
            if (k == 71) chk("rep_k71", int'(value), 4);
        end
        chk("rep_k80", int'(value), 4);
        up = 0; cyc(20);
        chk("rep_release", int'(value), 4);
        up = 1; cyc(55);
        chk("rep_second", int'(value), 6);
        rst = 0; init_value = 10; cyc();
        chk("rep_rst_abort", int'(value), 10);
        rst = 1; cyc(60);
        chk("rep_after_rst", int'(value), 10);
        up = 0; cyc();
        up = 1; cyc(10);
        chk("rep_en_edge", int'(value), 11);
        en = 0; cyc(); en = 1; cyc(60);
        chk("rep_en_abort", int'(value), 11);
        up = 0; cyc();
`endif

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
